// File: rtl/kmap_sweep_checker.sv
// kmap_sweep_checker: sweeps all minterms of an N_VARS-input function,
// captures its truth table and counts mismatches against an expected table.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin a sweep (accepted only in IDLE)
//   exp_table           expected value per minterm, latched at start
//   care_mask           1 = compare minterm, 0 = don't-care, latched at start
//   abcd                minterm driven to the function (a = MSB)
//   f_in                function output for the current abcd
//   busy                high while the sweep runs
//   done                one-cycle pulse at sweep completion
//   table_out           captured truth table, bit i = f(minterm i)
//   mismatch_cnt        cared minterms where f_in != exp_table
//   pass                mismatch_cnt == 0, valid from done until next start

module kmap_sweep_checker #(
    parameter int N_VARS = 4,
    parameter int SETTLE = 1,
    localparam int TABLE_W = 2 ** N_VARS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [TABLE_W-1:0]  exp_table,
    input  logic [TABLE_W-1:0]  care_mask,
    output logic [N_VARS-1:0]   abcd,
    input  logic                f_in,
    output logic                busy,
    output logic                done,
    output logic [TABLE_W-1:0]  table_out,
    output logic [N_VARS:0]     mismatch_cnt,
    output logic                pass
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SLAST = SW'(SETTLE - 1);
    localparam logic [N_VARS-1:0] ALAST = N_VARS'(TABLE_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TABLE_W-1:0] exp_q;
    logic [TABLE_W-1:0] care_q;
    logic [SW-1:0]      settle_cnt;
    logic               sample;
    logic               last;
    logic               miss;
    logic [N_VARS:0]    cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (sample && last) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sample fires on the last settle cycle of the current minterm
    always_comb begin
        busy    = (state == RUN);
        done    = (state == FINISH);
        sample  = (state == RUN) && (settle_cnt == SLAST);
        last    = (abcd == ALAST);
        miss    = care_q[abcd] & (f_in ^ exp_q[abcd]);
        cnt_nxt = mismatch_cnt + {{N_VARS{1'b0}}, miss};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            abcd         <= '0;
            settle_cnt   <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            exp_q        <= '0;
            care_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        exp_q        <= exp_table;
                        care_q       <= care_mask;
                        table_out    <= '0;
                        mismatch_cnt <= '0;
                        pass         <= 1'b0;
                        abcd         <= '0;
                        settle_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (sample) begin
                        table_out[abcd] <= f_in;
                        mismatch_cnt    <= cnt_nxt;
                        settle_cnt      <= '0;
                        if (last) begin
                            pass <= (cnt_nxt == '0);
                        end else begin
                            abcd <= abcd + 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    abcd <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// tb_kmap_sweep_checker: scoreboard bench for kmap_sweep_checker,
// one instance with SETTLE = 1 and one with SETTLE = 3.

module tb_kmap_sweep_checker;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  cnt;
        logic        pass;
        int          start_edge;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [15:0] exp1, care1, exp3, care3;
    logic [3:0]  abcd1, abcd3;
    logic        f1, f3;
    logic        busy1, busy3, done1, done3;
    logic [15:0] table1, table3;
    logic [4:0]  cnt1, cnt3;
    logic        pass1, pass3;

    int mode1 = 0;
    int mode3 = 0;
    int n_cmp = 0;
    int n_err = 0;
    int ecount = 0;
    int done1_n = 0;
    int done3_n = 0;
    int hold3 = 0;
    logic [3:0] prev3 = '0;
    logic prev_busy3 = 1'b0;
    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    always #5 clk = ~clk;

    kmap_sweep_checker #(.N_VARS(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .exp_table(exp1), .care_mask(care1), .abcd(abcd1),
        .f_in(f1), .busy(busy1), .done(done1), .table_out(table1),
        .mismatch_cnt(cnt1), .pass(pass1)
    );

    kmap_sweep_checker #(.N_VARS(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3),
        .exp_table(exp3), .care_mask(care3), .abcd(abcd3),
        .f_in(f3), .busy(busy3), .done(done3), .table_out(table3),
        .mismatch_cnt(cnt3), .pass(pass3)
    );

    // mode 0: dc as 1, 1: dc as 1 + m5 forced, 2: dc as 0, 3: tied 0
    function automatic logic kmodel(logic [3:0] m, int mode);
        logic [15:0] t;
        t = 16'hDD0C;
        case (mode)
            0: t = t | 16'h2210;
            1: t = t | 16'h2230;
            2: t = t;
            default: t = 16'h0000;
        endcase
        return t[m];
    endfunction

    always_comb f1 = kmodel(abcd1, mode1);
    always_comb f3 = kmodel(abcd3, mode3);

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        ecount++;
        if (done1) begin
            done1_n++;
            if (q1.size() == 0) begin
                check("d1_spurious_done", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check("d1_cycle", ecount - e1.start_edge + 1, e1.cyc);
                check("d1_table", table1, e1.tbl);
                check("d1_cnt", cnt1, e1.cnt);
                check("d1_pass", pass1, e1.pass);
            end
        end
        if (done3) begin
            done3_n++;
            if (q3.size() == 0) begin
                check("d3_spurious_done", 1, 0);
            end else begin
                e3 = q3.pop_front();
                check("d3_cycle", ecount - e3.start_edge + 1, e3.cyc);
                check("d3_table", table3, e3.tbl);
                check("d3_cnt", cnt3, e3.cnt);
                check("d3_pass", pass3, e3.pass);
            end
        end
        if (busy3) begin
            if (!prev_busy3) begin
                hold3 = 1;
                prev3 = abcd3;
            end else if (abcd3 == prev3) begin
                hold3++;
            end else begin
                check("d3_hold", hold3, 3);
                check("d3_step", abcd3, prev3 + 4'd1);
                hold3 = 1;
                prev3 = abcd3;
            end
        end
        prev_busy3 = busy3;
    end

    task automatic run1(int mode, logic [15:0] et, logic [15:0] ct,
                        logic [15:0] t, logic [4:0] n, logic p);
        exp_t x;
        int d0;
        bit got;
        mode1 = mode;
        @(negedge clk);
        exp1 = et;
        care1 = ct;
        start1 = 1'b1;
        @(posedge clk);
        #2;
        start1 = 1'b0;
        x.tbl = t;
        x.cnt = n;
        x.pass = p;
        x.start_edge = ecount;
        x.cyc = 17;
        q1.push_back(x);
        check("d1_busy_start", busy1, 1);
        exp1 = ~et;
        care1 = ~ct;
        d0 = done1_n;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #2;
            got = (done1_n != d0);
        end
        if (!got) begin
            check("d1_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #2;
            check("d1_done_drop", done1, 0);
            check("d1_busy_idle", busy1, 0);
            check("d1_abcd_idle", abcd1, 0);
            check("d1_table_hold", table1, t);
            check("d1_pass_hold", pass1, p);
        end
    endtask

    task automatic run3(logic [15:0] t, logic [4:0] n, logic p);
        exp_t x;
        int d0;
        bit got;
        mode3 = 0;
        @(negedge clk);
        exp3 = 16'hDD0C;
        care3 = 16'hDDEF;
        start3 = 1'b1;
        @(posedge clk);
        #2;
        start3 = 1'b0;
        x.tbl = t;
        x.cnt = n;
        x.pass = p;
        x.start_edge = ecount;
        x.cyc = 49;
        q3.push_back(x);
        exp3 = 16'h0000;
        care3 = 16'hFFFF;
        d0 = done3_n;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #2;
            got = (done3_n != d0);
            start3 = (i == 5 || i == 20 || i == 33);
        end
        if (!got) begin
            check("d3_timeout", 0, 1);
        end else begin
            start3 = 1'b1;
            @(posedge clk);
            #2;
            start3 = 1'b0;
            check("d3_done_drop", done3, 0);
            check("d3_finish_start_ignored", busy3, 0);
            repeat (4) @(posedge clk);
            #2;
            check("d3_done_count", done3_n - d0, 1);
            check("d3_still_idle", busy3, 0);
        end
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        exp1 = '0;
        care1 = '0;
        exp3 = '0;
        care3 = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_abcd", abcd1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_table", table1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_pass", pass1, 0);
        @(negedge clk);
        reset = 1'b0;

        run1(0, 16'hDD0C, 16'hDDEF, 16'hFF1C, 5'd0, 1'b1);
        run1(1, 16'hDD0C, 16'hDDEF, 16'hFF3C, 5'd1, 1'b0);
        run1(2, 16'hDD0C, 16'hDDEF, 16'hDD0C, 5'd0, 1'b1);
        run1(3, 16'hFFFF, 16'hFFFF, 16'h0000, 5'd16, 1'b0);

        mode1 = 0;
        @(negedge clk);
        exp1 = 16'hDD0C;
        care1 = 16'hDDEF;
        start1 = 1'b1;
        @(posedge clk);
        #2;
        start1 = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #2;
            hit = (abcd1 == 4'd7);
        end
        check("t5_reach7", hit, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("t5_busy", busy1, 0);
        check("t5_abcd", abcd1, 0);
        check("t5_done", done1, 0);
        check("t5_table", table1, 0);
        check("t5_cnt", cnt1, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        run1(0, 16'hDD0C, 16'hDDEF, 16'hFF1C, 5'd0, 1'b1);

        run3(16'hFF1C, 5'd0, 1'b1);

        check("q1_empty", q1.size(), 0);
        check("q3_empty", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
